// File: rtl/pcihellocore_pulse_leds.sv
// Avalon-MM output port for the pcihellocore fabric: direct write, atomic set/clear
// and self-clearing timed pulses sharing one down-counter, with 1-cycle registered readback.
module pcihellocore_pulse_leds #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      PULSE_CYCLES = 50,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_active
);

  localparam int unsigned     CW         = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0]   PULSE_LOAD = CW'(PULSE_CYCLES);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_OUTSET = 2'd1,
    REG_OUTCLR = 2'd2,
    REG_PULSE  = 2'd3
  } reg_e;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [31:0]      readdata_d;
  logic [WIDTH-1:0] wval;
  logic             wr;
  logic             expire;
  reg_e             sel;

  assign sel    = reg_e'(address);
  assign wr     = chipselect & ~write_n;
  assign wval   = writedata[WIDTH-1:0];
  // A PULSE write on the expiry edge retriggers instead of expiring.
  assign expire = (cnt_q == CW'(1)) && !(wr && sel == REG_PULSE);

  // Timer step and expiry are applied first; the write then layers on top,
  // which yields the documented collision results for every address.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    data_d = data_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (expire) begin
      data_d = data_d & ~mask_d;
      mask_d = '0;
      cnt_d  = '0;
    end

    if (wr) begin
      unique case (sel)
        REG_DATA: begin
          data_d = wval;
          mask_d = '0;
          cnt_d  = '0;
        end
        REG_OUTSET: data_d = data_d | wval;
        REG_OUTCLR: begin
          data_d = data_d & ~wval;
          mask_d = mask_d & ~wval;
        end
        REG_PULSE: begin
          data_d = data_q | wval;
          mask_d = mask_q | wval;
          cnt_d  = PULSE_LOAD;
        end
        default: ;
      endcase
    end
  end

  // Readback always reflects the pre-write register contents.
  always_comb begin
    readdata_d = '0;
    unique case (sel)
      REG_DATA:   readdata_d = 32'(data_q);
      REG_OUTSET: readdata_d = 32'(mask_q);
      REG_OUTCLR: readdata_d = 32'(cnt_q);
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      data_q       <= RESET_VALUE;
      mask_q       <= '0;
      cnt_q        <= '0;
      readdata     <= '0;
      pulse_active <= 1'b0;
    end else begin
      data_q       <= data_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      readdata     <= readdata_d;
      pulse_active <= (cnt_d != '0);
    end
  end

  assign out_port = data_q;

endmodule

// File: tb/tb_pcihellocore_pulse_leds.sv
// Self-checking bench for pcihellocore_pulse_leds: table-driven register vectors plus
// hand-written pulse, retrigger, cancel, expiry-collision and mid-pulse reset sequences.
module tb_pcihellocore_pulse_leds;

  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_active;

  int total = 0;
  int bad   = 0;

  pcihellocore_pulse_leds #(
    .WIDTH(8),
    .PULSE_CYCLES(50),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .pulse_active(pulse_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [7:0]  e_out;
    logic [31:0] e_rd;
    logic        e_pa;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic cycle(input logic rst, input logic cs, input logic wn,
                       input logic [1:0] addr, input logic [31:0] wd);
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    cycle(1'b0, 1'b1, 1'b0, addr, wd);
  endtask

  task automatic idle(input logic [1:0] addr);
    cycle(1'b0, 1'b0, 1'b1, addr, 32'h0);
  endtask

  task automatic idles(input int n);
    for (int j = 0; j < n; j++) idle(2'd0);
  endtask

  initial begin
    //            rst   cs    wn    addr  wdata          out    rd            pa
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        RV,    32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        RV,    32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0F,       8'h0F, 32'h0000_00A5, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h30,       8'h3F, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h03,       8'h3C, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        8'h3C, 32'h3C,       1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'hFF,       8'h3C, 32'h3C,       1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'hFF,       8'h3C, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd1, 32'hFF,       8'h3C, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFF_FF00, 8'h00, 32'h3C,      1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        8'h00, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h12,       RV,    32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        RV,    32'h0000_00A5, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rst, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].e_out));
      check($sformatf("vec%0d readdata", i), readdata, vecs[i].e_rd);
      check($sformatf("vec%0d pulse_active", i), 32'(pulse_active), 32'(vecs[i].e_pa));
    end

    // Basic pulse: 0x81 high for exactly 50 cycles, counter readable as it counts down.
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h81);
    check("pulse start out", 32'(out_port), 32'h81);
    check("pulse start active", 32'(pulse_active), 32'h1);
    for (int k = 1; k <= 51; k++) begin
      if (k == 10) begin
        idle(2'd1);
        check("pulse mask read", readdata, 32'h81);
      end else if (k == 20) begin
        idle(2'd3);
        check("pulse addr3 read", readdata, 32'h0);
      end else begin
        idle(2'd2);
        check($sformatf("pulse cnt k=%0d", k), readdata, 32'(51 - k));
      end
      check($sformatf("pulse out k=%0d", k), 32'(out_port), (k < 50) ? 32'h81 : 32'h0);
      check($sformatf("pulse active k=%0d", k), 32'(pulse_active), (k < 50) ? 32'h1 : 32'h0);
    end

    // Retrigger: second pulse write restarts the shared timer for both bits.
    wr(2'd3, 32'h01);
    idles(19);
    wr(2'd3, 32'h02);
    check("retrig both set", 32'(out_port), 32'h03);
    idles(49);
    check("retrig held 49", 32'(out_port), 32'h03);
    idle(2'd0);
    check("retrig cleared 50", 32'(out_port), 32'h00);
    check("retrig inactive", 32'(pulse_active), 32'h0);

    // Direct write cancels a running pulse.
    wr(2'd3, 32'h0F);
    idles(5);
    wr(2'd0, 32'h55);
    check("cancel out", 32'(out_port), 32'h55);
    check("cancel inactive", 32'(pulse_active), 32'h0);
    idle(2'd2);
    check("cancel cnt", readdata, 32'h0);
    idles(60);
    check("cancel held", 32'(out_port), 32'h55);

    // Collision: OUTSET on expiry edge keeps the newly set bit.
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h01);
    idles(49);
    wr(2'd1, 32'h01);
    check("coll set out", 32'(out_port), 32'h01);
    check("coll set inactive", 32'(pulse_active), 32'h0);
    idle(2'd1);
    check("coll set mask", readdata, 32'h0);

    // Collision: OUTCLR on expiry edge clears both masked and written bits.
    wr(2'd0, 32'h10);
    wr(2'd3, 32'h01);
    check("coll clr pre", 32'(out_port), 32'h11);
    idles(49);
    wr(2'd2, 32'h10);
    check("coll clr out", 32'(out_port), 32'h00);
    check("coll clr inactive", 32'(pulse_active), 32'h0);

    // Collision: PULSE on expiry edge retriggers instead of expiring.
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h01);
    idles(49);
    wr(2'd3, 32'h04);
    check("coll pulse out", 32'(out_port), 32'h05);
    check("coll pulse active", 32'(pulse_active), 32'h1);
    idle(2'd2);
    check("coll pulse cnt", readdata, 32'd50);
    idles(48);
    check("coll pulse held", 32'(out_port), 32'h05);
    idle(2'd0);
    check("coll pulse expired", 32'(out_port), 32'h00);

    // Reset mid-pulse at CNT=10 abandons the pulse.
    wr(2'd3, 32'h3C);
    idles(39);
    idle(2'd2);
    check("pre-reset cnt", readdata, 32'd11);
    cycle(1'b1, 1'b0, 1'b1, 2'd2, 32'h0);
    check("midreset out", 32'(out_port), 32'(RV));
    check("midreset inactive", 32'(pulse_active), 32'h0);
    idle(2'd2);
    check("midreset cnt", readdata, 32'h0);
    idles(15);
    check("midreset held", 32'(out_port), 32'(RV));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
